// File: rtl/aq_djpeg_ycbcr_rd_pkg.sv
// Shared constants and types for the YCbCr MCU buffer read sequencer.
// One MCU is 16x16 samples addressed raster-order as {y[3:0], x[3:0]}.
package aq_djpeg_ycbcr_rd_pkg;

    localparam int MCU_PIXELS = 256;
    localparam int ADDR_W     = $clog2(MCU_PIXELS);
    localparam int DATA_W_DEF = 9;

    localparam logic [ADDR_W-1:0] MCU_LAST_ADDR = 8'hFF;

    // Per-pixel sideband carried through the output FIFO with the samples.
    typedef struct packed {
        logic       last;
        logic [3:0] y;
        logic [3:0] x;
    } pix_tag_t;

    function automatic pix_tag_t make_tag(input logic [ADDR_W-1:0] addr);
        pix_tag_t t;
        t.last = (addr == MCU_LAST_ADDR);
        t.y    = addr[7:4];
        t.x    = addr[3:0];
        return t;
    endfunction

endpackage

// File: rtl/aq_djpeg_ycbcr_rd_pix_fifo.sv
// Small synchronous FIFO holding captured pixels; flush empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module aq_djpeg_ycbcr_rd_pix_fifo #(
    parameter  int WIDTH = 36,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only: no reset, contents are meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && !flush_i)
            assert (!(push_i && full && !pop_i)) else $error("pix_fifo overflow");
    end
`endif

endmodule

// File: rtl/aq_djpeg_ycbcr_rd.sv
// Read-side sequencer for the double-banked YCbCr MCU buffer: walks 0x00..0xFF,
// captures the 1-cycle-latency samples and streams them out with backpressure.
module aq_djpeg_ycbcr_rd
    import aq_djpeg_ycbcr_rd_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DataInit,
    input  logic              MemEnable,
    output logic [7:0]        MemAddress,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemY,
    input  logic [DATA_W-1:0] MemCb,
    input  logic [DATA_W-1:0] MemCr,
    output logic              PixelValid,
    input  logic              PixelReady,
    output logic [DATA_W-1:0] PixelY,
    output logic [DATA_W-1:0] PixelCb,
    output logic [DATA_W-1:0] PixelCr,
    output logic [3:0]        PixelPosX,
    output logic [3:0]        PixelPosY,
    output logic              PixelLast
);

    localparam int FIFO_W = 3 * DATA_W + $bits(pix_tag_t);
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam int OCC_W  = CNT_W + 1;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] tag_q;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [OCC_W-1:0]  occ;
    logic              credit_ok;
    logic              issue;
    logic              push;
    logic              pop;
    logic [FIFO_W-1:0] push_data;
    logic [FIFO_W-1:0] head_data;
    logic [DATA_W-1:0] head_y, head_cb, head_cr;
    pix_tag_t          head_tag;

    assign pop = PixelValid & PixelReady;

    // Credit: a slot must be free for everything already queued or in flight
    // once this cycle's pop is taken into account, so the FIFO cannot overflow.
    assign occ       = {1'b0, fifo_count}
                     + {{CNT_W{1'b0}}, inflight_q}
                     - {{CNT_W{1'b0}}, pop};
    assign credit_ok = (occ < OCC_W'(OUT_DEPTH));
    assign issue     = rst & MemEnable & ~DataInit & credit_ok;

    assign MemRead    = issue;
    assign MemAddress = addr_q;

    always_comb begin
        addr_d     = addr_q;
        inflight_d = 1'b0;
        if (DataInit) begin
            addr_d = '0;
        end else if (issue) begin
            addr_d     = addr_q + 1'b1;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
        end
    end

    // Address of the read in flight; only meaningful while inflight_q is set.
    always_ff @(posedge clk) begin
        if (issue) tag_q <= addr_q;
    end

    assign push      = inflight_q & ~DataInit;
    assign push_data = {MemY, MemCb, MemCr, make_tag(tag_q)};

    aq_djpeg_ycbcr_rd_pix_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (DataInit),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_data),
        .rdata_o (head_data),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign {head_y, head_cb, head_cr, head_tag} = head_data;

    // Outputs are forced to zero while nothing is valid so reset and idle
    // never expose uninitialised FIFO storage.
    assign PixelValid = ~fifo_empty;
    assign PixelY     = PixelValid ? head_y       : '0;
    assign PixelCb    = PixelValid ? head_cb      : '0;
    assign PixelCr    = PixelValid ? head_cr      : '0;
    assign PixelPosX  = PixelValid ? head_tag.x   : 4'd0;
    assign PixelPosY  = PixelValid ? head_tag.y   : 4'd0;
    assign PixelLast  = PixelValid ? head_tag.last : 1'b0;

endmodule

// File: tb/tb_aq_djpeg_ycbcr_rd.sv
// Bench for aq_djpeg_ycbcr_rd: bank-level buffer model plus an in-order pixel
// stream reference (pixel k of a stream = bank base+k/256, address k%256).
module tb_aq_djpeg_ycbcr_rd;

    localparam int DW = 9;
    localparam int OD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          DataInit = 1'b0;
    logic          MemEnable;
    logic [7:0]    MemAddress;
    logic          MemRead;
    logic [DW-1:0] MemY, MemCb, MemCr;
    logic          PixelValid;
    logic          PixelReady = 1'b0;
    logic [DW-1:0] PixelY, PixelCb, PixelCr;
    logic [3:0]    PixelPosX, PixelPosY;
    logic          PixelLast;
    logic [35:0]   obs_px;

    int n_chk = 0;
    int n_fail = 0;
    int bank_rd = 0;
    int loaded = 0;
    int sb_k = 0;
    int sb_base = 0;
    int issue_cnt = 0;
    int ff_cnt = 0;
    int cyc = 0;
    int first_iss = 0;
    int last_ff = 0;
    logic        hold_pending = 1'b0;
    logic [35:0] held = '0;

    aq_djpeg_ycbcr_rd #(.DATA_W(DW), .OUT_DEPTH(OD)) dut (
        .clk        (clk),
        .rst        (rst),
        .DataInit   (DataInit),
        .MemEnable  (MemEnable),
        .MemAddress (MemAddress),
        .MemRead    (MemRead),
        .MemY       (MemY),
        .MemCb      (MemCb),
        .MemCr      (MemCr),
        .PixelValid (PixelValid),
        .PixelReady (PixelReady),
        .PixelY     (PixelY),
        .PixelCb    (PixelCb),
        .PixelCr    (PixelCr),
        .PixelPosX  (PixelPosX),
        .PixelPosY  (PixelPosY),
        .PixelLast  (PixelLast)
    );

    always #5 clk = ~clk;

    assign obs_px    = {PixelY, PixelCb, PixelCr, PixelPosX, PixelPosY, PixelLast};
    assign MemEnable = (loaded != bank_rd);

    // Buffer model: a full bank is ready while loaded banks exceed consumed ones;
    // reading 0xFF consumes the bank. Unread cycles return garbage.
    always @(posedge clk) begin
        if (MemRead) begin
            MemY  <= {bank_rd[0], MemAddress};
            MemCb <= {1'b0, MemAddress ^ 8'h55};
            MemCr <= {1'b0, ~MemAddress};
            if (MemAddress == 8'hFF) bank_rd <= bank_rd + 1;
        end else begin
            MemY  <= DW'($urandom);
            MemCb <= DW'($urandom);
            MemCr <= DW'($urandom);
        end
    end

    function automatic logic [35:0] model_px(input int k, input int base);
        int         b;
        logic [7:0] a;
        b = base + k / 256;
        a = 8'(k % 256);
        return {b[0], a, 1'b0, a ^ 8'h55, 1'b0, ~a, a[3:0], a[7:4], (k % 256) == 255};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        #1;
        if (MemRead) begin
            issue_cnt++;
            if (issue_cnt == 1) first_iss = cyc;
            if (MemAddress == 8'hFF) begin
                ff_cnt++;
                last_ff = cyc;
            end
        end
        if (hold_pending) check("head_stable", {PixelValid, obs_px}, {1'b1, held});
        if (PixelValid && PixelReady) begin
            check($sformatf("pix%0d", sb_k), obs_px, model_px(sb_k, sb_base));
            sb_k++;
        end
        hold_pending = PixelValid && !PixelReady && !DataInit && rst;
        held = obs_px;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_stream(input int nbanks);
        loaded    = bank_rd + nbanks;
        sb_base   = bank_rd;
        sb_k      = 0;
        issue_cnt = 0;
        ff_cnt    = 0;
    endtask

    task automatic run_until(input int target, input int budget, input bit rand_ready);
        int n;
        n = 0;
        while (sb_k < target && n < budget) begin
            if (rand_ready) PixelReady = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        check("reach_target", 64'(sb_k), 64'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with random inputs
        loaded = bank_rd + 1;
        for (int i = 0; i < 4; i++) begin
            DataInit   = 1'($urandom);
            PixelReady = 1'($urandom);
            tick();
            check("reset_outputs", {MemRead, MemAddress, PixelValid, obs_px}, '0);
        end
        DataInit = 1'b0;
        loaded   = bank_rd;
        rst      = 1'b1;
        tick();

        // 2: one MCU, free-running sink, latency and single 0xFF read
        start_stream(1);
        PixelReady = 1'b1;
        tick();
        check("latency_edge1", PixelValid, 1'b0);
        tick();
        check("latency_edge2", PixelValid, 1'b1);
        run_until(256, 400, 1'b0);
        check("mcu1_ff_reads", ff_cnt, 1);
        check("mcu1_issues", issue_cnt, 256);
        for (int i = 0; i < 3; i++) tick();
        check("mcu1_drained", {PixelValid, MemEnable, 32'(sb_k)}, {2'b00, 32'd256});

        // 3: backpressure at pixel 10
        start_stream(1);
        run_until(10, 100, 1'b0);
        PixelReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_state", {MemRead, PixelValid}, 2'b01);
        end
        check("stall_no_pop", sb_k, 10);
        PixelReady = 1'b1;
        run_until(256, 400, 1'b0);
        check("stall_ff_reads", ff_cnt, 1);

        // 4: two banks back to back, no bubble across 0xFF->0x00
        start_stream(2);
        run_until(512, 700, 1'b0);
        check("b2b_ff_reads", ff_cnt, 2);
        check("b2b_issues", issue_cnt, 512);
        check("b2b_no_bubble", last_ff - first_iss, 511);

        // 5: DataInit with data in flight
        start_stream(1);
        run_until(100, 200, 1'b0);
        DataInit = 1'b1;
        #1;
        check("datainit_noread", MemRead, 1'b0);
        tick();
        DataInit = 1'b0;
        loaded   = bank_rd;
        #1;
        check("datainit_flush", {PixelValid, MemAddress}, 9'd0);
        hold_pending = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("datainit_no_stale", PixelValid, 1'b0);
        end
        start_stream(1);
        run_until(256, 400, 1'b0);
        check("restart_ff_reads", ff_cnt, 1);

        // 6: no bank ready, random sink
        for (int i = 0; i < 100; i++) begin
            PixelReady = 1'($urandom);
            tick();
            check("idle_quiet", {MemRead, PixelValid}, 2'b00);
        end

        // 7: one MCU under random backpressure
        start_stream(1);
        run_until(256, 3000, 1'b1);
        check("rand_ff_reads", ff_cnt, 1);
        PixelReady = 1'b1;

        // 8: asynchronous reset mid-MCU
        start_stream(1);
        run_until(50, 100, 1'b0);
        rst = 1'b0;
        #1;
        check("midreset_outputs", {MemRead, MemAddress, PixelValid, obs_px}, '0);
        loaded = bank_rd;
        tick();
        tick();
        rst = 1'b1;
        hold_pending = 1'b0;
        tick();
        check("midreset_release", {PixelValid, MemAddress}, 9'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
